// File: rtl/mem_wb_stage_p_if.sv
// Bundle between mem_wb_stage_p and its neighbours: the upstream instruction
// handshake, the variable-latency memory port and the write-back result.
interface mem_wb_stage_p_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
);
  // Handshakes: an instruction moves when inValid & inReady are both high at a
  // rising edge; a memory request completes when memAck is high at a rising
  // edge while memReq is high. memReq/memAddr/memWdata/memWrOut stay stable
  // until that edge, and outValid is a single-cycle pulse with no back-pressure.
  logic                  inValid;
  logic                  inReady;
  logic                  memEn;
  logic                  memWrt;
  logic                  halt;
  logic                  regWrt;
  logic [2:0]            regWrtSrc;
  logic [REG_ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0]     aluOut;
  logic [DATA_W-1:0]     setVal;
  logic [DATA_W-1:0]     reg1Data;
  logic [DATA_W-1:0]     reg2Data;
  logic [DATA_W-1:0]     nextPc;
  logic [15:0]           instr;

  logic                  memReq;
  logic                  memWrOut;
  logic [DATA_W-1:0]     memAddr;
  logic [DATA_W-1:0]     memWdata;
  logic [DATA_W-1:0]     memRdata;
  logic                  memAck;

  logic                  outValid;
  logic                  regWrtOut;
  logic [REG_ADDR_W-1:0] writeRegOut;
  logic [DATA_W-1:0]     regWriteData;
  logic [DATA_W-1:0]     memOut;
  logic                  err;
  logic                  dumpOut;

  modport slave (
    input  inValid, memEn, memWrt, halt, regWrt, regWrtSrc, writeReg,
    input  aluOut, setVal, reg1Data, reg2Data, nextPc, instr,
    input  memRdata, memAck,
    output inReady, memReq, memWrOut, memAddr, memWdata,
    output outValid, regWrtOut, writeRegOut, regWriteData, memOut, err, dumpOut
  );

  modport master (
    output inValid, memEn, memWrt, halt, regWrt, regWrtSrc, writeReg,
    output aluOut, setVal, reg1Data, reg2Data, nextPc, instr,
    output memRdata, memAck,
    input  inReady, memReq, memWrOut, memAddr, memWdata,
    input  outValid, regWrtOut, writeRegOut, regWriteData, memOut, err, dumpOut
  );
endinterface

// File: rtl/mem_wb_stage_p.sv
// Memory / write-back stage: one instruction in flight, multi-cycle memory
// access, seven-way write-back select. Optional memAck timeout: MEM_TIMEOUT_EN.
module mem_wb_stage_p #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst,
  mem_wb_stage_p_if.slave  bus,
  output logic [1:0]       state_o
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  if (DATA_W < 16) begin : g_bad_data_w
    $error("mem_wb_stage_p: DATA_W must be >= 16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_wb_stage_p: TIMEOUT must be >= 1");
  end

  state_e                state_q;
  logic                  halt_q, regwrt_q, store_q;
  logic [2:0]            src_q;
  logic [REG_ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0]     pre_q;

  logic                  mem_req_q, mem_wr_q;
  logic [DATA_W-1:0]     mem_addr_q, mem_wdata_q;
  logic                  out_valid_q, reg_wrt_out_q, err_q, dump_q;
  logic [REG_ADDR_W-1:0] write_reg_out_q;
  logic [DATA_W-1:0]     wb_data_q, mem_out_q;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  // Every source except fresh load data is known at capture time; source 0
  // falls back to the last load value for instructions that do not load.
  logic [DATA_W-1:0] pre_d;
  always_comb begin
    pre_d = '0;
    case (bus.regWrtSrc)
      3'd0:    pre_d = mem_out_q;
      3'd1:    pre_d = bus.aluOut;
      3'd2:    pre_d = bus.nextPc;
      3'd3:    pre_d = bus.setVal;
      3'd4:    pre_d = {{(DATA_W-8){bus.instr[7]}}, bus.instr[7:0]};
      3'd5:    pre_d = {bus.reg1Data[DATA_W-9:0], bus.instr[7:0]};
      3'd6:    pre_d = bit_rev(bus.reg1Data);
      default: pre_d = '0;
    endcase
  end

  logic                  xfer, ack, tmo, retire, r_ill, r_rw, r_halt;
  logic [2:0]            r_src;
  logic [REG_ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0]     r_val;

  always_comb begin
    xfer   = (state_q == S_IDLE) && bus.inValid;
    ack    = (state_q == S_WAIT) && mem_req_q && bus.memAck;
    retire = (xfer && !bus.memEn) || ack;
    if (xfer) begin
      r_src  = bus.regWrtSrc;
      r_rw   = bus.regWrt;
      r_halt = bus.halt;
      r_wreg = bus.writeReg;
      r_val  = pre_d;
    end else begin
      r_src  = src_q;
      r_rw   = regwrt_q;
      r_halt = halt_q;
      r_wreg = wreg_q;
      r_val  = (src_q == 3'd0 && !store_q) ? bus.memRdata : pre_q;
    end
    r_ill = (r_src == 3'd7);
  end

`ifdef MEM_TIMEOUT_EN
  assign tmo = (state_q == S_WAIT) && mem_req_q && !bus.memAck &&
               (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      halt_q          <= 1'b0;
      regwrt_q        <= 1'b0;
      store_q         <= 1'b0;
      src_q           <= '0;
      wreg_q          <= '0;
      pre_q           <= '0;
      mem_req_q       <= 1'b0;
      mem_wr_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      out_valid_q     <= 1'b0;
      reg_wrt_out_q   <= 1'b0;
      write_reg_out_q <= '0;
      wb_data_q       <= '0;
      mem_out_q       <= '0;
      err_q           <= 1'b0;
      dump_q          <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q           <= '0;
`endif
    end else begin
      out_valid_q   <= 1'b0;
      reg_wrt_out_q <= 1'b0;
      dump_q        <= 1'b0;
      case (state_q)
        S_IDLE: if (xfer) begin
          halt_q   <= bus.halt;
          regwrt_q <= bus.regWrt;
          store_q  <= bus.memWrt;
          src_q    <= bus.regWrtSrc;
          wreg_q   <= bus.writeReg;
          pre_q    <= pre_d;
          if (bus.memEn) begin
            state_q     <= S_WAIT;
            mem_req_q   <= 1'b1;
            mem_wr_q    <= bus.memWrt;
            mem_addr_q  <= bus.aluOut;
            mem_wdata_q <= bus.reg2Data;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (ack || tmo) begin
            mem_req_q <= 1'b0;
            mem_wr_q  <= 1'b0;
          end
          if (ack && !store_q) mem_out_q <= bus.memRdata;
`ifdef MEM_TIMEOUT_EN
          if (!ack && !tmo) cnt_q <= cnt_q + 1'b1;
`endif
        end
        default: ;
      endcase

      if (retire) begin
        out_valid_q     <= 1'b1;
        reg_wrt_out_q   <= r_rw && !r_ill;
        write_reg_out_q <= r_wreg;
        wb_data_q       <= r_ill ? '0 : r_val;
        err_q           <= err_q || r_ill;
        // One dump per event: a halt, or the first rise of err.
        dump_q          <= r_halt || (r_ill && !err_q);
        state_q         <= r_halt ? S_HALTED : S_IDLE;
      end

      if (tmo) begin
        out_valid_q     <= 1'b1;
        reg_wrt_out_q   <= 1'b0;
        write_reg_out_q <= wreg_q;
        wb_data_q       <= '0;
        err_q           <= 1'b1;
        dump_q          <= 1'b1;
        state_q         <= halt_q ? S_HALTED : S_IDLE;
      end
    end
  end

  logic unused_instr;
  assign unused_instr = ^bus.instr[15:8];

  assign state_o          = state_q;
  assign bus.inReady      = (state_q == S_IDLE);
  assign bus.memReq       = mem_req_q;
  assign bus.memWrOut     = mem_wr_q;
  assign bus.memAddr      = mem_addr_q;
  assign bus.memWdata     = mem_wdata_q;
  assign bus.outValid     = out_valid_q;
  assign bus.regWrtOut    = reg_wrt_out_q;
  assign bus.writeRegOut  = write_reg_out_q;
  assign bus.regWriteData = wb_data_q;
  assign bus.memOut       = mem_out_q;
  assign bus.err          = err_q;
  assign bus.dumpOut      = dump_q;
endmodule

// File: tb/tb_mem_wb_stage_p.sv
// Bench for mem_wb_stage_p: directed cases plus random instruction stream,
// memory responder with random latency, and a queue-based write-back model.
module tb_mem_wb_stage_p;
  localparam int DATA_W = 16;
  localparam int RA     = 3;
  localparam int TMO    = 4;
  localparam int W      = 3 + RA + 2 * DATA_W;
`ifdef MEM_TIMEOUT_EN
  localparam int MAX_LAT = 2;
`else
  localparam int MAX_LAT = 6;
`endif

  typedef struct packed {
    logic              mem_en;
    logic              mem_wrt;
    logic              halt;
    logic              reg_wrt;
    logic [2:0]        src;
    logic [RA-1:0]     wreg;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] setv;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [DATA_W-1:0] npc;
    logic [15:0]       ins;
  } txn_t;

  typedef struct packed {
    logic              dump;
    logic              err;
    logic              rw;
    logic [RA-1:0]     wreg;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] data;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_wb_stage_p_if #(.DATA_W(DATA_W), .REG_ADDR_W(RA)) bus ();
  logic [1:0] dbg_state;

  mem_wb_stage_p #(.DATA_W(DATA_W), .REG_ADDR_W(RA), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // scoreboard state
  logic [W-1:0]      exp_q[$];
  logic              err_m = 1'b0;
  logic [DATA_W-1:0] mem_m = '0;
  int                n_checks = 0;
  int                n_pass   = 0;

  txn_t              pend;
  logic              mute = 1'b0;
  logic              busy = 1'b0;
  logic              late_ack = 1'b0;
  logic              acked_last = 1'b0;
  int                lat = 0;
  int                force_lat = -1;
  logic              force_data_en = 1'b0;
  logic [DATA_W-1:0] force_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [DATA_W-1:0] model_wb(input txn_t t, input logic [DATA_W-1:0] ld);
    logic [DATA_W-1:0] v;
    v = '0;
    case (t.src)
      3'd0: v = ld;
      3'd1: v = t.alu;
      3'd2: v = t.npc;
      3'd3: v = t.setv;
      3'd4: v = DATA_W'(t.ins[7:0]) - (t.ins[7] ? DATA_W'(256) : DATA_W'(0));
      3'd5: v = DATA_W'(t.r1 * 256 + DATA_W'(t.ins[7:0]));
      3'd6: for (int i = 0; i < DATA_W; i++) v[i] = t.r1[DATA_W-1-i];
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic push_exp(input txn_t t, input logic [DATA_W-1:0] ld);
    exp_t e;
    logic ill;
    ill = (t.src == 3'd7);
    if (t.mem_en && !t.mem_wrt) mem_m = ld;
    e.dump = t.halt || (ill && !err_m);
    err_m  = err_m || ill;
    e.err  = err_m;
    e.rw   = t.reg_wrt && !ill;
    e.wreg = t.wreg;
    e.mem  = mem_m;
    e.data = ill ? '0 : model_wb(t, ld);
    exp_q.push_back(W'(e));
  endtask

  function automatic txn_t rand_txn(input bit allow_mem);
    txn_t t;
    t.mem_en  = allow_mem && ($urandom_range(0, 9) < 4);
    t.mem_wrt = 1'($urandom_range(0, 1));
    t.halt    = 1'b0;
    t.reg_wrt = 1'($urandom_range(0, 1));
    t.src     = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
    t.wreg    = RA'($urandom);
    t.alu     = DATA_W'($urandom);
    t.setv    = DATA_W'($urandom);
    t.r1      = DATA_W'($urandom);
    t.r2      = DATA_W'($urandom);
    t.npc     = DATA_W'($urandom);
    t.ins     = 16'($urandom);
    return t;
  endfunction

  function automatic txn_t alu_txn(input logic [2:0] src, input logic [DATA_W-1:0] alu,
                                   input logic [DATA_W-1:0] r1, input logic [15:0] ins);
    txn_t t;
    t      = '0;
    t.src  = src;
    t.alu  = alu;
    t.r1   = r1;
    t.ins  = ins;
    t.reg_wrt = 1'b1;
    t.wreg = 3'd5;
    t.npc  = 16'h0102;
    t.setv = 16'h0001;
    return t;
  endfunction

  // driver tasks (called at a falling edge)
  task automatic drive_fields(input txn_t t);
    bus.memEn     = t.mem_en;
    bus.memWrt    = t.mem_wrt;
    bus.halt      = t.halt;
    bus.regWrt    = t.reg_wrt;
    bus.regWrtSrc = t.src;
    bus.writeReg  = t.wreg;
    bus.aluOut    = t.alu;
    bus.setVal    = t.setv;
    bus.reg1Data  = t.r1;
    bus.reg2Data  = t.r2;
    bus.nextPc    = t.npc;
    bus.instr     = t.ins;
  endtask

  task automatic send(input txn_t t);
    int guard;
    guard = 0;
    while (!bus.inReady && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.inReady) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    drive_fields(t);
    bus.inValid = 1'b1;
    if (!t.mem_en) push_exp(t, mem_m);
    else pend = t;
    @(negedge clk);
    bus.inValid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus.memReq) && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.inValid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.inReady, 1);
    check("rst_out_valid", bus.outValid, 0);
    check("rst_mem_req", bus.memReq, 0);
    check("rst_mem_wr", bus.memWrOut, 0);
    check("rst_err", bus.err, 0);
    check("rst_dump", bus.dumpOut, 0);
    check("rst_reg_wrt", bus.regWrtOut, 0);
    check("rst_wb_data", bus.regWriteData, 0);
    check("rst_mem_out", bus.memOut, 0);
    exp_q.delete();
    err_m = 1'b0;
    mem_m = '0;
    busy  = 1'b0;
    acked_last = 1'b0;
    rst = 1'b0;
  endtask

  // memory responder
  initial begin
    logic [DATA_W-1:0] rd;
    bus.memAck   = 1'b0;
    bus.memRdata = '0;
    forever begin
      @(negedge clk);
      bus.memAck = 1'b0;
      if (acked_last && !rst) check("req_drop", bus.memReq, 0);
      acked_last = 1'b0;
      if (late_ack) begin
        bus.memAck   = 1'b1;
        bus.memRdata = DATA_W'($urandom);
        late_ack     = 1'b0;
      end else if (!rst && !mute && bus.memReq) begin
        if (!busy) begin
          busy = 1'b1;
          lat  = (force_lat >= 0) ? force_lat : $urandom_range(0, MAX_LAT);
          force_lat = -1;
          check("req_addr", bus.memAddr, pend.alu);
          check("req_wdata", bus.memWdata, pend.r2);
          check("req_wr", bus.memWrOut, pend.mem_wrt);
          check("wait_not_ready", bus.inReady, 0);
        end else begin
          check("addr_held", bus.memAddr, pend.alu);
        end
        if (lat == 0) begin
          rd = force_data_en ? force_data : DATA_W'($urandom);
          force_data_en = 1'b0;
          bus.memRdata  = rd;
          bus.memAck    = 1'b1;
          push_exp(pend, pend.mem_wrt ? mem_m : rd);
          busy       = 1'b0;
          acked_last = 1'b1;
        end else begin
          lat--;
        end
      end else if (!rst && !bus.memReq && !busy && $urandom_range(0, 7) == 0) begin
        bus.memAck   = 1'b1;
        bus.memRdata = DATA_W'($urandom);
      end
    end
  end

  // write-back monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.outValid) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", 1, 0);
          end else begin
            e = exp_t'(exp_q.pop_front());
            check("wb_data", bus.regWriteData, e.data);
            check("wb_reg", bus.writeRegOut, e.wreg);
            check("wb_regwrt", bus.regWrtOut, e.rw);
            check("wb_memout", bus.memOut, e.mem);
            check("wb_err", bus.err, e.err);
            check("wb_dump", bus.dumpOut, e.dump);
          end
        end else begin
          check("quiet", {bus.dumpOut, bus.regWrtOut}, 0);
        end
      end
    end
  end

  // stimulus
  initial begin
    txn_t t;
    int   cnt;
    bus.inValid = 1'b0;
    drive_fields('0);
    @(negedge clk);
    do_reset();

    send(alu_txn(3'd1, 16'h1234, 16'h0000, 16'h0000));

    t = alu_txn(3'd0, 16'h0040, 16'h0000, 16'h0000);
    t.mem_en = 1'b1;
    force_lat = 2;
    force_data = 16'hBEEF;
    force_data_en = 1'b1;
    send(t);
    wait_drain();
    check("load_memout", bus.memOut, 16'hBEEF);

    send(alu_txn(3'd4, 16'h0000, 16'h0000, 16'h1280));
    send(alu_txn(3'd5, 16'h0000, 16'h00AB, 16'h00CD));
    send(alu_txn(3'd6, 16'h0000, 16'h0001, 16'h0000));
    send(alu_txn(3'd7, 16'h5555, 16'h0000, 16'h0000));
    send(alu_txn(3'd1, 16'h7777, 16'h0000, 16'h0000));
    wait_drain();
    check("err_sticky", bus.err, 1);

    for (int i = 0; i < 300; i++) begin
      send(rand_txn(1'b1));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    wait_drain();

    // reset while a request is outstanding, then a late ack
    mute = 1'b1;
    t = rand_txn(1'b0);
    t.mem_en = 1'b1;
    send(t);
    check("wait_req_up", bus.memReq, 1);
    do_reset();
    late_ack = 1'b1;
    repeat (3) @(negedge clk);
    mute = 1'b0;
    check("after_late_ack_ready", bus.inReady, 1);

`ifdef MEM_TIMEOUT_EN
    mute = 1'b1;
    t = alu_txn(3'd1, 16'h0080, 16'h0000, 16'h0000);
    t.mem_en = 1'b1;
    err_m = 1'b1;
    exp_q.push_back(W'({1'b1, 1'b1, 1'b0, t.wreg, mem_m, {DATA_W{1'b0}}}));
    pend = t;
    send(t);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.memReq) cnt++;
    end
    check("timeout_req_cycles", cnt, TMO);
    late_ack = 1'b1;
    repeat (3) @(negedge clk);
    mute = 1'b0;
    wait_drain();
    check("timeout_err", bus.err, 1);
`endif

    // halt
    send(alu_txn(3'd7, 16'h0000, 16'h0000, 16'h0000));
    t = alu_txn(3'd2, 16'h0000, 16'h0000, 16'h0000);
    t.halt = 1'b1;
    send(t);
    wait_drain();
    drive_fields(alu_txn(3'd1, 16'hAAAA, 16'h0000, 16'h0000));
    bus.inValid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halted_not_ready", bus.inReady, 0);
    end
    bus.inValid = 1'b0;
    check("halted_err", bus.err, 1);
    do_reset();
    send(alu_txn(3'd1, 16'h4321, 16'h0000, 16'h0000));
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
